// File: rtl/div_ctrl_if.sv
// Divider handshake bundle between the execute stage and div_ctrl.
//   start_i  : E-stage instruction is a divide (held while stalled)
//   signed_i : 1 = DIV (two's complement), 0 = DIVU
//   annul_i  : cancel any in-flight divide (exception/flush)
//   a_i, b_i : dividend / divisor, sampled on accept
//   stall_o  : divide stall to the hazard unit
//   ready_o  : one-cycle pulse, result_o valid
//   result_o : {remainder (HI), quotient (LO)}
// The master modport is the execute stage; the slave modport is the divider.
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic               annul_i;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i, signed_i, annul_i, a_i, b_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, a_i, b_i,
    output stall_o, ready_o, result_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for the execute stage (DIV/DIVU).
// One quotient bit per cycle over WIDTH cycles; the hazard unit freezes
// F/D/E while stall_o is high. Divide by zero finishes straight away with
// quotient all ones and remainder equal to the raw dividend.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : div_ctrl_if slave (start/signed/annul/operands in,
//         stall/ready/result out)
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  div_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   divisor;
  logic [CW-1:0]      count;
  logic               q_neg;
  logic               r_neg;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quot_next;
  logic [WIDTH-1:0]   q_final;
  logic [WIDTH-1:0]   r_final;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the trial difference only if it did not go negative.
  // The shifted value needs WIDTH+1 bits because rem < divisor < 2^WIDTH.
  always_comb begin
    shifted   = {rem, quot[WIDTH-1]};
    fits      = (shifted >= {1'b0, divisor});
    rem_next  = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], fits};
    q_final   = q_neg ? -quot_next : quot_next;
    r_final   = r_neg ? -rem_next  : rem_next;
    abs_a     = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
    abs_b     = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
  end

  // Stall is combinational so an annul releases the pipeline in the same
  // cycle; DONE deliberately drops stall so the divide leaves E.
  assign bus.stall_o  = ~rst & ~bus.annul_i &
                        ((state == BUSY) | ((state == IDLE) & bus.start_i));
  assign bus.ready_o  = ready & ~bus.annul_i;
  assign bus.result_o = result;

  // Sequencer: IDLE accepts, BUSY iterates WIDTH times, DONE presents the
  // sign-corrected result for one cycle. Annul returns to IDLE without
  // touching the result register. The signed flags are zero in DIVU mode,
  // so the fix-up stage becomes a pass-through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      count   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      ready   <= 1'b0;
      result  <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            q_neg <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
            r_neg <= bus.signed_i & bus.a_i[WIDTH-1];
            count <= '0;
            if (bus.b_i == '0) begin
              result <= {bus.a_i, {WIDTH{1'b1}}};
              ready  <= 1'b1;
              state  <= DONE;
            end else begin
              rem     <= '0;
              quot    <= abs_a;
              divisor <= abs_b;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            rem   <= rem_next;
            quot  <= quot_next;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
              result <= {r_final, q_final};
              ready  <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a cycle-level behavioural model built
// from plain integer division, compared every cycle, plus directed cases
// with hand-computed literal results.
module tb_div_ctrl;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_ctrl_if #(.WIDTH(WIDTH)) bus ();

  div_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  always @(posedge clk) cycle++;

  // Compare one value and report mismatches.
  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Reference arithmetic: truncating division on 64-bit integers, which
  // also yields the wrapped quotient for most-negative / -1.
  function automatic logic [63:0] refDivide(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Behavioural model: how many busy cycles remain, whether this is the
  // result cycle, and the result currently on display.
  int          busyLeft = 0;
  bit          inDone   = 1'b0;
  logic [63:0] expRes   = '0;
  logic [63:0] pendRes  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busyLeft = 0;
      inDone   = 1'b0;
      expRes   = '0;
    end else if (bus.annul_i) begin
      busyLeft = 0;
      inDone   = 1'b0;
    end else if (inDone) begin
      inDone = 1'b0;
    end else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) begin
        inDone = 1'b1;
        expRes = pendRes;
      end
    end else if (bus.start_i) begin
      pendRes = refDivide(bus.a_i, bus.b_i, bus.signed_i);
      if (bus.b_i == 32'd0) begin
        inDone = 1'b1;
        expRes = pendRes;
      end else begin
        busyLeft = WIDTH;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit expStall, expReady;
    expStall = !rst && !bus.annul_i &&
               (busyLeft > 0 || (!inDone && bus.start_i));
    expReady = !rst && inDone && !bus.annul_i;
    checkOutput("model stall", 64'(bus.stall_o), 64'(expStall));
    checkOutput("model ready", 64'(bus.ready_o), 64'(expReady));
    checkOutput("model result", bus.result_o, expRes);
  end

  // Drive all inputs just after a rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input bit sgn, input bit st, input bit an);
    @(posedge clk);
    #1;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.signed_i = sgn;
    bus.start_i  = st;
    bus.annul_i  = an;
  endtask

  // Issue one divide with start held and wait (bounded) for ready.
  task automatic runDivide(input logic [31:0] a, input logic [31:0] b,
                           input bit sgn, input string name,
                           output int stallCycles, output logic [63:0] res,
                           output int readyCycle);
    bit gotReady;
    applyStimulus(a, b, sgn, 1'b1, 1'b0);
    stallCycles = 0;
    gotReady    = 1'b0;
    res         = '0;
    readyCycle  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ready_o) begin
        gotReady   = 1'b1;
        res        = bus.result_o;
        readyCycle = cycle;
        break;
      end
      if (bus.stall_o) stallCycles++;
    end
    checkOutput({name, " ready seen"}, 64'(gotReady), 64'd1);
  endtask

  initial begin
    int          sc, rc1, rc2, readyCount;
    logic [63:0] res;
    logic [31:0] ra, rb;
    int          sel;

    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.annul_i  = 1'b0;
    bus.a_i      = '0;
    bus.b_i      = '0;

    #1;
    checkOutput("reset stall", 64'(bus.stall_o), 64'd0);
    checkOutput("reset ready", 64'(bus.ready_o), 64'd0);
    checkOutput("reset result", bus.result_o, 64'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed cases");
    runDivide(32'd100, 32'd7, 1'b0, "u100/7", sc, res, rc1);
    checkOutput("u100/7 stall cycles", 64'(sc), 64'd33);
    checkOutput("u100/7 result", res, 64'h00000002_0000000E);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    runDivide(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7/2", sc, res, rc1);
    checkOutput("s-7/2 result", res, 64'hFFFFFFFF_FFFFFFFD);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    runDivide(32'd7, 32'hFFFF_FFFE, 1'b1, "s7/-2", sc, res, rc1);
    checkOutput("s7/-2 result", res, 64'h00000001_FFFFFFFD);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    runDivide(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "minneg/-1", sc, res, rc1);
    checkOutput("minneg/-1 result", res, 64'h00000000_80000000);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    runDivide(32'h1234, 32'd0, 1'b1, "div0", sc, res, rc1);
    checkOutput("div0 stall cycles", 64'(sc), 64'd1);
    checkOutput("div0 result", res, 64'h00001234_FFFFFFFF);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high throughout.
    runDivide(32'd100, 32'd7, 1'b0, "b2b first", sc, res, rc1);
    checkOutput("b2b first result", res, 64'h00000002_0000000E);
    runDivide(32'hFFFF_FFFF, 32'h10, 1'b0, "b2b second", sc, res, rc2);
    checkOutput("b2b second result", res, 64'h0000000F_0FFFFFFF);
    checkOutput("b2b ready spacing", 64'(rc2 - rc1), 64'd34);
    checkOutput("b2b second stall cycles", 64'(sc), 64'd33);

    // Annul at BUSY iteration 10.
    applyStimulus(32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    #1;
    checkOutput("annul stall", 64'(bus.stall_o), 64'd0);
    checkOutput("annul ready", 64'(bus.ready_o), 64'd0);
    applyStimulus(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    readyCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready_o) readyCount++;
    end
    checkOutput("annul no ready", 64'(readyCount), 64'd0);
    checkOutput("annul result held", bus.result_o, 64'h0000000F_0FFFFFFF);
    runDivide(32'd100, 32'd7, 1'b0, "after annul", sc, res, rc1);
    checkOutput("after annul stall cycles", 64'(sc), 64'd33);
    checkOutput("after annul result", res, 64'h00000002_0000000E);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of BUSY.
    applyStimulus(32'd1000, 32'd3, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    #1;
    checkOutput("async rst stall", 64'(bus.stall_o), 64'd0);
    checkOutput("async rst ready", 64'(bus.ready_o), 64'd0);
    checkOutput("async rst result", bus.result_o, 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    runDivide(32'hFFFF_FFF9, 32'd2, 1'b1, "after rst", sc, res, rc1);
    checkOutput("after rst stall cycles", 64'(sc), 64'd33);
    checkOutput("after rst result", res, 64'hFFFFFFFF_FFFFFFFD);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 7);
      ra  = (sel == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      applyStimulus(ra, rb, 1'($urandom), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 49) == 0));
    end
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle iterative divider with its own sequencing FSM, placed in the execute stage beside the ALU.
- Executes DIV/DIVU one quotient bit per cycle (restoring algorithm).
- Drives the execute-stage divide stall consumed by the hazard unit, which freezes F/D/E and holds E operands stable while the divide runs.
- Delivers {remainder, quotient} for the HI/LO write.

Parameters:
- WIDTH, 32, operand width in bits; iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start_i  input  1  E-stage instruction is a divide; held high while stalled
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- annul_i  input  1  cancel in-flight divide (exception/flush); highest priority
- a_i  input  WIDTH  dividend; sampled on accept
- b_i  input  WIDTH  divisor; sampled on accept
- stall_o  output  1  divide stall to hazard unit (div_stallE)
- ready_o  output  1  one-cycle pulse: result_o valid
- result_o  output  2*WIDTH  {remainder (HI), quotient (LO)}

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, internal remainder/quotient/operand registers=0, result_o=0, ready_o=0. stall_o=0 while in reset.
- States:
  - IDLE: stall_o = start_i & ~annul_i.
    - Accept when start_i=1 and annul_i=0: latch |a|, |b| (magnitudes only when signed_i=1), the quotient sign (sign(a) XOR sign(b)), the remainder sign (sign(a)), and signed_i; clear counter.
    - After accept: if b_i==0 go to DONE; else go to BUSY.
  - BUSY: stall_o=1.
    - Each cycle: shift {rem, quot} left by 1; trial-subtract divisor from rem. If non-negative, keep the difference and set quot LSB=1.
    - Counter increments each cycle; after WIDTH iterations go to DONE.
  - DONE: stall_o=0, ready_o=1 for exactly this cycle; result_o registered and valid.
    - start_i is ignored in DONE. Because stall is low, the divide instruction leaves E this cycle.
    - Next state is IDLE.
- Latency (b≠0): accept cycle T; BUSY T+1..T+WIDTH; DONE T+WIDTH+1. stall_o is high for WIDTH+1 cycles (T..T+WIDTH).
- Back-to-back divides: a second divide arriving in IDLE the cycle after DONE is accepted normally. There are no dead cycles other than DONE.
- Sign fix-up, applied when entering DONE:
  - quotient negated if its sign flag is set;
  - remainder negated if the dividend was negative;
  - unsigned mode applies no fix-up.
- Most-negative / -1: magnitude result wraps; the quotient returns 0x80000000 (WIDTH=32) and the remainder returns 0.
- Divide by zero: the divide completes in 2 cycles (accept, DONE) with quotient = all ones and remainder = dividend (raw a_i); no sign fix-up; no trap.
- result_o holds its last value until the next DONE; it is not cleared on IDLE.
- annul_i:
  - In IDLE: blocks accept.
  - In BUSY or DONE: next state is IDLE.
  - In every case: stall_o forced 0 the same cycle (combinational), ready_o=0, and result_o is not updated.
- Simultaneous annul_i and start_i: annul wins; nothing is accepted.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; there is no partial result.
- Operand changes on a_i/b_i after accept have no effect.
- All arithmetic is WIDTH+1 bits internally for the trial subtract; no overflow flag.

Test Plan:
- Unsigned 100/7: start_i=1, signed_i=0, a=100, b=7 → stall_o high 33 cycles, ready_o pulse at cycle 33, result_o={0x00000002, 0x0000000E}.
- Signed −7/2: a=0xFFFFFFF9, b=2, signed_i=1 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat with 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: a=0x1234, b=0 → stall_o high 1 cycle, ready_o next cycle, result_o={0x00001234, 0xFFFFFFFF}.
- Annul mid-divide: accept 100/7, assert annul_i at BUSY iteration 10 → stall_o drops that cycle, no ready_o, result_o unchanged, FSM in IDLE next cycle. A new start after that runs the full 33 cycles.
- Back-to-back: 100/7 then 0xFFFFFFFF/0x10 (unsigned) with start_i continuously high → two ready_o pulses 34 cycles apart; second result {0x0000000F, 0x0FFFFFFF}.
- Async reset during BUSY: assert rst between clock edges → stall_o, ready_o, result_o go to 0 immediately; after release the FSM is IDLE and accepts a new divide.
